// File: rtl/eye_tracker_reg_bank.sv
// Host register bank for the EyeTracker: control regs plus frame-coherent channel snapshots.
// Optional interrupt output is enabled by defining EYE_TRACKER_REG_IRQ_EN.
module eye_tracker_reg_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH     = 7,
  parameter int unsigned CH_WIDTH   = 28
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR_WIDTH-1:0]        iADDR,
  input  logic                         iWE,
  input  logic                         iRE,
  input  logic [DATA_WIDTH-1:0]        iDATA,
  output logic [DATA_WIDTH-1:0]        oRD,
  input  logic                         iFVSYNC,
  input  logic [NUM_CH*CH_WIDTH-1:0]   iCH_DATA,
  output logic                         oUART_SW,
  output logic                         oVGA_OUT_MODE,
  output logic                         oCURSOR_EN,
  output logic                         oOUT_SEL,
  output logic [DATA_WIDTH-1:0]        oTHRESHOLD,
  output logic                         oIRQ
);

  localparam int unsigned BPC      = (CH_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned NumBytes = NUM_CH * BPC;
  localparam int unsigned PadWidth = BPC * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrThresh = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrFrame  = ADDR_WIDTH'(3);
  localparam int unsigned           SnapBase   = 4;

  // ctrl_q = {FREEZE, OUT_SEL, CURSOR_EN, VGA_OUT_MODE, UART_SW}
  logic [4:0]            ctrl_q;
  logic [DATA_WIDTH-1:0] thresh_q;
  logic                  new_q, ovr_q;
  logic [7:0]            frame_q;
  logic                  fvs_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [CH_WIDTH-1:0]   snap_q [NUM_CH];
  logic                  irq_en;

  logic [DATA_WIDTH-1:0] snap_bytes [NumBytes];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rise, status_rd, freeze;
  logic                  new_d, ovr_d;

  // Only bits [5:0] of write data carry meaning.
  logic unused_data;
  assign unused_data = ^iDATA[DATA_WIDTH-1:6];

  assign rise      = iFVSYNC & ~fvs_q;
  assign status_rd = iRE & (iADDR == AddrStatus);
  assign freeze    = ctrl_q[4];

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned b = 0; b < BPC; b++) begin
        snap_bytes[c*BPC + b] = DATA_WIDTH'(PadWidth'(snap_q[c]) >> (b * DATA_WIDTH));
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (iADDR == AddrCtrl)   rd_data = DATA_WIDTH'({irq_en, ctrl_q});
    if (iADDR == AddrThresh) rd_data = thresh_q;
    if (iADDR == AddrStatus) rd_data = DATA_WIDTH'({ovr_q, new_q});
    if (iADDR == AddrFrame)  rd_data = DATA_WIDTH'(frame_q);
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (iADDR == ADDR_WIDTH'(SnapBase + i)) rd_data = snap_bytes[i];
    end
  end

  // Read-to-clear first, then a frame rise overrides it.
  always_comb begin
    new_d = new_q;
    ovr_d = ovr_q;
    if (status_rd) begin
      new_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (rise) begin
      if (freeze) begin
        ovr_d = 1'b1;
      end else begin
        new_d = 1'b1;
        if (new_q) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q   <= 5'b01110;
      thresh_q <= DATA_WIDTH'(1);
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      frame_q  <= '0;
      fvs_q    <= 1'b0;
      rd_q     <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
    end else begin
      fvs_q <= iFVSYNC;
      new_q <= new_d;
      ovr_q <= ovr_d;
      rd_q  <= iRE ? rd_data : '0;
      if (iWE && iADDR == AddrCtrl)   ctrl_q   <= iDATA[4:0];
      if (iWE && iADDR == AddrThresh) thresh_q <= iDATA;
      if (rise && !freeze) begin
        frame_q <= frame_q + 8'd1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          snap_q[c] <= iCH_DATA[c*CH_WIDTH +: CH_WIDTH];
        end
      end
    end
  end

`ifdef EYE_TRACKER_REG_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (iWE && iADDR == AddrCtrl) irq_en_q <= iDATA[5];
      irq_q <= irq_en_q & new_q;
    end
  end

  assign irq_en = irq_en_q;
  assign oIRQ   = irq_q;
`else
  assign irq_en = 1'b0;
  assign oIRQ   = 1'b0;
`endif

  assign oRD           = rd_q;
  assign oUART_SW      = ctrl_q[0];
  assign oVGA_OUT_MODE = ctrl_q[1];
  assign oCURSOR_EN    = ctrl_q[2];
  assign oOUT_SEL      = ctrl_q[3];
  assign oTHRESHOLD    = thresh_q;

endmodule

// File: tb/tb_eye_tracker_reg_bank.sv
// Directed, scoreboard-based bench for eye_tracker_reg_bank.
module tb_eye_tracker_reg_bank;
  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int NCH = 7;
  localparam int CW  = 28;

  logic            CLK = 1'b0;
  logic            RST, iWE, iRE, iFVSYNC;
  logic [AW-1:0]   iADDR;
  logic [DW-1:0]   iDATA, oRD, oTHRESHOLD;
  logic [NCH*CW-1:0] ch_data;
  logic            oUART_SW, oVGA_OUT_MODE, oCURSOR_EN, oOUT_SEL, oIRQ;
  logic [CW-1:0]   ch_val [NCH];

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  always_comb begin
    ch_data = '0;
    for (int c = 0; c < NCH; c++) ch_data[c*CW +: CW] = ch_val[c];
  end

  eye_tracker_reg_bank dut (
    .CLK          (CLK),
    .RST          (RST),
    .iADDR        (iADDR),
    .iWE          (iWE),
    .iRE          (iRE),
    .iDATA        (iDATA),
    .oRD          (oRD),
    .iFVSYNC      (iFVSYNC),
    .iCH_DATA     (ch_data),
    .oUART_SW     (oUART_SW),
    .oVGA_OUT_MODE(oVGA_OUT_MODE),
    .oCURSOR_EN   (oCURSOR_EN),
    .oOUT_SEL     (oOUT_SEL),
    .oTHRESHOLD   (oTHRESHOLD),
    .oIRQ         (oIRQ)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    @(negedge CLK);
    iADDR = a;
    iRE   = 1'b1;
    exp_q.push_back(e);
    @(negedge CLK);
    iRE = 1'b0;
    check(tag, oRD, exp_q.pop_front());
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    iADDR = a;
    iDATA = d;
    iWE   = 1'b1;
    @(negedge CLK);
    iWE = 1'b0;
  endtask

  task automatic pulse();
    @(negedge CLK);
    iFVSYNC = 1'b1;
    @(negedge CLK);
    iFVSYNC = 1'b0;
  endtask

  initial begin
    RST = 1'b1; iWE = 1'b0; iRE = 1'b0; iFVSYNC = 1'b0; iADDR = '0; iDATA = '0;
    for (int c = 0; c < NCH; c++) ch_val[c] = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    check("rst_ord", oRD, 8'h00);
    check("rst_uart", {7'b0, oUART_SW}, 8'h00);
    check("rst_vga", {7'b0, oVGA_OUT_MODE}, 8'h01);
    check("rst_cursor", {7'b0, oCURSOR_EN}, 8'h01);
    check("rst_outsel", {7'b0, oOUT_SEL}, 8'h01);
    check("rst_thresh", oTHRESHOLD, 8'h01);
    check("rst_irq", {7'b0, oIRQ}, 8'h00);
    rd(6'h00, 8'h0E, "rst_ctrl");
    rd(6'h01, 8'h01, "rst_thr_rd");
    rd(6'h02, 8'h00, "rst_status");
    rd(6'h03, 8'h00, "rst_frame");
    @(negedge CLK);
    check("ord_idle", oRD, 8'h00);

    // First snapshot
    ch_val[0] = 28'h1234567;
    ch_val[1] = 28'hABCDEF1;
    ch_val[6] = 28'hFEDCBA9;
    pulse();
    rd(6'h08, 8'hF1, "snap1_b0");
    rd(6'h09, 8'hDE, "snap1_b1");
    rd(6'h0A, 8'hBC, "snap1_b2");
    rd(6'h0B, 8'h0A, "snap1_b3");
    rd(6'h04, 8'h67, "snap0_b0");
    rd(6'h1F, 8'h0F, "snap6_b3");
    rd(6'h03, 8'h01, "frame1");
    rd(6'h02, 8'h01, "status_new");
    rd(6'h02, 8'h00, "status_clr");

    // Overrun
    pulse();
    pulse();
    rd(6'h02, 8'h03, "status_ovr");
    rd(6'h02, 8'h00, "status_ovr_clr");

    // Threshold write, freeze
    wr(6'h01, 8'h5A);
    check("thr_out", oTHRESHOLD, 8'h5A);
    rd(6'h01, 8'h5A, "thr_rd");
    wr(6'h00, 8'h1E);
    check("outsel_out", {7'b0, oOUT_SEL}, 8'h01);
    ch_val[1] = 28'h1111111;
    pulse();
    rd(6'h08, 8'hF1, "frozen_snap");
    rd(6'h03, 8'h03, "frozen_frame");
    rd(6'h02, 8'h02, "frozen_status");
    wr(6'h00, 8'h0E);
    wr(6'h03, 8'hFF);
    wr(6'h02, 8'hFF);
    rd(6'h03, 8'h03, "ro_frame");
    rd(6'h02, 8'h00, "ro_status");

    // Writable CTRL bits
    wr(6'h00, 8'h3F);
`ifdef EYE_TRACKER_REG_IRQ_EN
    rd(6'h00, 8'h3F, "ctrl_all");
`else
    rd(6'h00, 8'h1F, "ctrl_all");
`endif
    check("uart_out", {7'b0, oUART_SW}, 8'h01);
    wr(6'h00, 8'h0E);
    rd(6'h3F, 8'h00, "unmapped");
    rd(6'h20, 8'h00, "past_snap");

    // Frame counter wrap: 3 + 253 = 256
    for (int i = 0; i < 253; i++) pulse();
    rd(6'h03, 8'h00, "frame_wrap");
    rd(6'h08, 8'h11, "wrap_snap");
    rd(6'h02, 8'h03, "wrap_status");

    // Rise coincident with STATUS read
    @(negedge CLK);
    iADDR = 6'h02; iRE = 1'b1; iFVSYNC = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge CLK);
    iRE = 1'b0; iFVSYNC = 1'b0;
    check("coinc_old", oRD, exp_q.pop_front());
    rd(6'h02, 8'h01, "coinc_after");
    rd(6'h03, 8'h01, "coinc_frame");

    // Write and read same register same cycle
    @(negedge CLK);
    iADDR = 6'h01; iDATA = 8'h33; iWE = 1'b1; iRE = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge CLK);
    iWE = 1'b0; iRE = 1'b0;
    check("wr_rd_old", oRD, exp_q.pop_front());
    rd(6'h01, 8'h33, "wr_rd_new");

    // FREEZE written on a rise: old value governs
    ch_val[1] = 28'h2222222;
    @(negedge CLK);
    iADDR = 6'h00; iDATA = 8'h1E; iWE = 1'b1; iFVSYNC = 1'b1;
    @(negedge CLK);
    iWE = 1'b0; iFVSYNC = 1'b0;
    rd(6'h03, 8'h02, "frz_race_frame");
    rd(6'h08, 8'h22, "frz_race_snap");
    rd(6'h00, 8'h1E, "frz_race_ctrl");
    rd(6'h02, 8'h01, "frz_race_status");
    wr(6'h00, 8'h0E);

    // Interrupt
    wr(6'h00, 8'h2E);
    pulse();
    @(negedge CLK);
`ifdef EYE_TRACKER_REG_IRQ_EN
    check("irq_set", {7'b0, oIRQ}, 8'h01);
`else
    check("irq_set", {7'b0, oIRQ}, 8'h00);
`endif
    rd(6'h02, 8'h01, "irq_status");
    @(negedge CLK);
    check("irq_clr", {7'b0, oIRQ}, 8'h00);

    // Reset during a read
    ch_val[1] = 28'h3333333;
    pulse();
    @(negedge CLK);
    iADDR = 6'h01; iRE = 1'b1; RST = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge CLK);
    iRE = 1'b0; RST = 1'b0;
    check("rst_mid_rd", oRD, exp_q.pop_front());
    check("rst_mid_irq", {7'b0, oIRQ}, 8'h00);
    check("rst_mid_thr", oTHRESHOLD, 8'h01);
    rd(6'h00, 8'h0E, "rst_mid_ctrl");
    rd(6'h02, 8'h00, "rst_mid_status");
    rd(6'h03, 8'h00, "rst_mid_frame");
    rd(6'h08, 8'h00, "rst_mid_snap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
